// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state encoding,
// opcode values and the opcode field extractor.
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_UPDATE = 3'd3,
        ST_HALT   = 3'd4
    } fetch_state_e;

    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_BEQZ = 4'hB;
    localparam logic [3:0] OP_RET  = 4'hC;
    localparam logic [3:0] OP_HLT  = 4'hF;

    function automatic logic [3:0] opcode_of(input logic [31:0] instr);
        return instr[31:28];
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// Saturating 8-bit wait counter for the instruction-memory handshake.
// hit flags the increment that brings the count up to TIMEOUT.
module fetch_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count_r;

    // wait-cycle counter, cleared on fetch entry, saturates at all-ones
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= 8'd0;
        end else if (clr) begin
            count_r <= 8'd0;
        end else if (inc && (count_r != 8'hFF)) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign hit = inc && (count_r == LAST);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: fetches the word at the PC, classifies its opcode and
// commands the program counter update for the next instruction.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          cstate,
    input  logic          rst,
    input  logic [AW-1:0] pc_q,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_data,
    input  logic          zero_flag,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    output logic          pc_en,
    output logic          pc_jumping,
    output logic          pc_gotoprev,
    output logic [AW-1:0] pc_d,
    output logic [DW-1:0] instr_out,
    output logic          instr_valid,
    output logic          halted,
    output logic          fetch_err
);

    localparam logic [AW-1:0] PC_ONE = AW'(1);

    fetch_state_e  state_r, state_s;
    logic [DW-1:0] ir_r, ir_s;
    logic [3:0]    opcode_s;
    logic          timer_clr_s, timer_inc_s, timer_hit_s;
    logic          dec_jump_s, dec_prev_s;
    logic [AW-1:0] dec_pcd_s, sext_s;
    logic          req_r, req_s, en_r, en_s, jump_r, jump_s, prev_r, prev_s;
    logic          valid_r, valid_s, halted_r, halted_s, err_r, err_s;
    logic [AW-1:0] addr_r, addr_s, pcd_r, pcd_s;

    assign opcode_s    = opcode_of(ir_r[31:0]);
    assign sext_s      = {{(AW-16){ir_r[15]}}, ir_r[15:0]};
    assign timer_inc_s = (state_r == ST_FETCH) && !imem_ack;
    assign timer_clr_s = (state_r != ST_FETCH) && (state_s == ST_FETCH);

    fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk (cstate),
        .rst (rst),
        .clr (timer_clr_s),
        .inc (timer_inc_s),
        .hit (timer_hit_s)
    );

    // FSM state register
    always_ff @(posedge cstate) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // next-state logic; an ack on the timeout edge still completes the fetch
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   state_s = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    state_s = ST_DECODE;
                end else if (timer_hit_s) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DECODE: state_s = ST_UPDATE;
            ST_UPDATE: state_s = (opcode_s == OP_HLT) ? ST_HALT : ST_FETCH;
            ST_HALT:   state_s = ST_HALT;
            default:   state_s = ST_IDLE;
        endcase
    end

    // opcode classification and jump target, consumed on the DECODE->UPDATE edge
    always_comb begin
        dec_jump_s = 1'b0;
        dec_prev_s = 1'b0;
        dec_pcd_s  = {AW{1'b0}};
        case (opcode_s)
            OP_JMP: begin
                dec_jump_s = 1'b1;
                dec_pcd_s  = {{(AW-28){1'b0}}, ir_r[27:0]};
            end
            OP_BEQZ: begin
                if (zero_flag) begin
                    dec_jump_s = 1'b1;
                    dec_pcd_s  = pc_q + PC_ONE + sext_s;
                end else begin
                    dec_jump_s = 1'b0;
                end
            end
            OP_RET:  dec_prev_s = 1'b1;
            default: dec_jump_s = 1'b0;
        endcase
    end

    // next values for the registered outputs, derived from the upcoming state
    always_comb begin
        req_s    = (state_s == ST_FETCH);
        halted_s = (state_s == ST_HALT);
        err_s    = err_r | ((state_r == ST_FETCH) && timer_hit_s);
        if (timer_clr_s) begin
            addr_s = pc_q;
        end else begin
            addr_s = addr_r;
        end
        if ((state_r == ST_FETCH) && imem_ack) begin
            ir_s = imem_data;
        end else begin
            ir_s = ir_r;
        end
        if (state_s == ST_UPDATE) begin
            en_s    = 1'b1;
            valid_s = 1'b1;
            jump_s  = dec_jump_s;
            prev_s  = dec_prev_s;
            pcd_s   = dec_pcd_s;
        end else begin
            en_s    = 1'b0;
            valid_s = 1'b0;
            jump_s  = 1'b0;
            prev_s  = 1'b0;
            pcd_s   = {AW{1'b0}};
        end
    end

    // output and instruction registers
    always_ff @(posedge cstate) begin
        if (!rst) begin
            req_r    <= 1'b0;
            addr_r   <= {AW{1'b0}};
            en_r     <= 1'b0;
            jump_r   <= 1'b0;
            prev_r   <= 1'b0;
            pcd_r    <= {AW{1'b0}};
            valid_r  <= 1'b0;
            halted_r <= 1'b0;
            err_r    <= 1'b0;
            ir_r     <= {DW{1'b0}};
        end else begin
            req_r    <= req_s;
            addr_r   <= addr_s;
            en_r     <= en_s;
            jump_r   <= jump_s;
            prev_r   <= prev_s;
            pcd_r    <= pcd_s;
            valid_r  <= valid_s;
            halted_r <= halted_s;
            err_r    <= err_s;
            ir_r     <= ir_s;
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = addr_r;
    assign pc_en       = en_r;
    assign pc_jumping  = jump_r;
    assign pc_gotoprev = prev_r;
    assign pc_d        = pcd_r;
    assign instr_out   = ir_r;
    assign instr_valid = valid_r;
    assign halted      = halted_r;
    assign fetch_err   = err_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed opcode scenarios plus randomized
// instruction streams against a behavioural opcode-table model and a cntr model.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam int TIMEOUT = 16;

    logic        cstate = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_q = 32'd0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = 32'd0;
    logic        zero_flag = 1'b0;
    logic        imem_req, pc_en, pc_jumping, pc_gotoprev, instr_valid, halted, fetch_err;
    logic [31:0] imem_addr, pc_d, instr_out;

    fetch_ctrl #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT)) dut (
        .cstate(cstate), .rst(rst), .pc_q(pc_q), .imem_ack(imem_ack),
        .imem_data(imem_data), .zero_flag(zero_flag), .imem_req(imem_req),
        .imem_addr(imem_addr), .pc_en(pc_en), .pc_jumping(pc_jumping),
        .pc_gotoprev(pc_gotoprev), .pc_d(pc_d), .instr_out(instr_out),
        .instr_valid(instr_valid), .halted(halted), .fetch_err(fetch_err)
    );

    always #5 cstate = ~cstate;

    typedef struct packed {
        logic        jump;
        logic        prev;
        logic        halt;
        logic [31:0] pcd;
    } exp_t;

    int errors = 0;
    int checks = 0;
    logic [31:0] pc = 32'h0000_0100;
    logic [31:0] prev_pc = 32'd0;

    logic        obs_tmo, obs_req_dec, obs_en_dec, obs_en, obs_jump, obs_prev, obs_valid;
    logic        obs_en_after, obs_req_after, obs_halted_after;
    logic [31:0] obs_addr, obs_instr, obs_pcd, obs_addr_after;

    // opcode table written straight from the instruction set description
    function automatic exp_t ref_cmd(input logic [31:0] instr, input bit zero,
                                     input logic [31:0] cur);
        exp_t e;
        longint off;
        int op;
        e = '0;
        op = int'(instr >> 28);
        if (op == 10) begin
            e.jump = 1'b1;
            e.pcd = instr % 32'h1000_0000;
        end else if (op == 11 && zero) begin
            off = longint'(instr % 32'h0001_0000);
            if (off > 32767) off = off - 65536;
            e.jump = 1'b1;
            e.pcd = 32'(longint'(cur) + 1 + off);
        end else if (op == 12) begin
            e.prev = 1'b1;
        end else if (op == 15) begin
            e.halt = 1'b1;
        end
        return e;
    endfunction

    // One full fetch/decode/update transaction; the cntr model updates on the
    // falling edge of UPDATE so the next fetch sees the new PC.
    task automatic run_instr(input logic [31:0] instr, input bit zero, input int delay,
                             input bit noise);
        int n;
        logic [31:0] nxt;
        obs_tmo = 1'b0;
        n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            @(negedge cstate);
            n++;
        end
        if (imem_req !== 1'b1) begin
            obs_tmo = 1'b1;
            return;
        end
        obs_addr = imem_addr;
        repeat (delay) @(negedge cstate);
        imem_ack = 1'b1;
        imem_data = instr;
        zero_flag = zero;
        @(negedge cstate);
        obs_req_dec = imem_req;
        obs_en_dec = pc_en;
        obs_instr = instr_out;
        imem_ack = noise;
        imem_data = $urandom;
        @(negedge cstate);
        imem_ack = 1'b0;
        obs_en = pc_en; obs_jump = pc_jumping; obs_prev = pc_gotoprev;
        obs_pcd = pc_d; obs_valid = instr_valid;
        if (pc_en === 1'b1) begin
            nxt = pc_gotoprev ? prev_pc : (pc_jumping ? pc_d : pc + 32'd1);
            prev_pc = pc;
            pc = nxt;
            pc_q = pc;
        end
        @(negedge cstate);
        obs_en_after = pc_en;
        obs_req_after = imem_req;
        obs_addr_after = imem_addr;
        obs_halted_after = halted;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        pc_q = pc;
        for (int i = 0; i < 2; i++) begin
            @(negedge cstate);
            checks++;
            if ({imem_req, imem_addr, pc_en, pc_jumping, pc_gotoprev, pc_d, instr_out,
                 instr_valid, halted, fetch_err} !== 103'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got req=%b addr=%h en=%b err=%b halted=%b want all 0",
                         i, imem_req, imem_addr, pc_en, fetch_err, halted);
            end
        end
        rst = 1'b1;
        @(negedge cstate);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== pc) begin
            errors++;
            $display("FAIL reset_first_fetch: got req=%b addr=%h want req=1 addr=%h",
                     imem_req, imem_addr, pc);
        end
    endtask

    task automatic test_alu();
        logic [31:0] p0;
        p0 = pc;
        run_instr(32'h0000_0001, 1'b0, 1, 1'b0);
        checks++;
        if (obs_tmo || obs_addr !== p0 || obs_req_dec !== 1'b0 || obs_en_dec !== 1'b0) begin
            errors++;
            $display("FAIL alu_fetch: got tmo=%b addr=%h req=%b en=%b want 0 %h 0 0",
                     obs_tmo, obs_addr, obs_req_dec, obs_en_dec, p0);
        end
        checks++;
        if ({obs_en, obs_jump, obs_prev, obs_valid} !== 4'b1001 || obs_pcd !== 32'd0) begin
            errors++;
            $display("FAIL alu_cmd: got en/jmp/prev/valid=%b pcd=%h want 1001 0",
                     {obs_en, obs_jump, obs_prev, obs_valid}, obs_pcd);
        end
        checks++;
        if (obs_en_after !== 1'b0 || obs_req_after !== 1'b1 || obs_addr_after !== p0 + 32'd1) begin
            errors++;
            $display("FAIL alu_next: got en=%b req=%b addr=%h want 0 1 %h",
                     obs_en_after, obs_req_after, obs_addr_after, p0 + 32'd1);
        end
    endtask

    task automatic test_jmp();
        run_instr(32'hA000_0040, 1'b0, 0, 1'b0);
        checks++;
        if ({obs_en, obs_jump, obs_prev, obs_valid} !== 4'b1101 || obs_pcd !== 32'h0000_0040) begin
            errors++;
            $display("FAIL jmp_cmd: got %b pcd=%h want 1101 00000040",
                     {obs_en, obs_jump, obs_prev, obs_valid}, obs_pcd);
        end
        checks++;
        if (obs_addr_after !== 32'h0000_0040 || obs_instr !== 32'hA000_0040) begin
            errors++;
            $display("FAIL jmp_next: got addr=%h instr=%h want 00000040 a0000040",
                     obs_addr_after, obs_instr);
        end
    endtask

    task automatic test_beqz();
        run_instr(32'hA000_0010, 1'b0, 2, 1'b0);
        run_instr(32'hB000_FFFE, 1'b1, 1, 1'b0);
        checks++;
        if ({obs_en, obs_jump, obs_prev} !== 3'b110 || obs_pcd !== 32'h0000_000F) begin
            errors++;
            $display("FAIL beqz_taken: got %b pcd=%h want 110 0000000f",
                     {obs_en, obs_jump, obs_prev}, obs_pcd);
        end
        run_instr(32'hB000_FFFE, 1'b0, 1, 1'b0);
        checks++;
        if ({obs_en, obs_jump, obs_prev} !== 3'b100 || obs_addr_after !== 32'h0000_0010) begin
            errors++;
            $display("FAIL beqz_not_taken: got %b next=%h want 100 00000010",
                     {obs_en, obs_jump, obs_prev}, obs_addr_after);
        end
        run_instr(32'hA000_0000, 1'b0, 0, 1'b0);
        run_instr(32'hB000_FFFE, 1'b1, 0, 1'b0);
        checks++;
        if (obs_pcd !== 32'hFFFF_FFFF || obs_addr_after !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL beqz_wrap_low: got pcd=%h next=%h want ffffffff ffffffff",
                     obs_pcd, obs_addr_after);
        end
        run_instr(32'h0000_0003, 1'b0, 0, 1'b0);
        checks++;
        if (obs_addr_after !== 32'h0000_0000 || obs_jump !== 1'b0) begin
            errors++;
            $display("FAIL pc_wrap: got next=%h jmp=%b want 00000000 0",
                     obs_addr_after, obs_jump);
        end
    endtask

    task automatic test_ret();
        logic [31:0] back;
        back = prev_pc;
        run_instr(32'hC000_0000, 1'b0, 3, 1'b0);
        checks++;
        if ({obs_en, obs_jump, obs_prev, obs_valid} !== 4'b1011 || obs_en_after !== 1'b0) begin
            errors++;
            $display("FAIL ret_cmd: got %b en_after=%b want 1011 0",
                     {obs_en, obs_jump, obs_prev, obs_valid}, obs_en_after);
        end
        checks++;
        if (obs_addr_after !== back) begin
            errors++;
            $display("FAIL ret_next: got addr=%h want %h", obs_addr_after, back);
        end
    endtask

    task automatic test_ack_boundary();
        run_instr(32'h0000_0007, 1'b0, TIMEOUT - 1, 1'b0);
        checks++;
        if (obs_tmo || obs_en !== 1'b1 || fetch_err !== 1'b0 || obs_req_after !== 1'b1) begin
            errors++;
            $display("FAIL ack_at_timeout: got tmo=%b en=%b err=%b req=%b want 0 1 0 1",
                     obs_tmo, obs_en, fetch_err, obs_req_after);
        end
    endtask

    task automatic test_random();
        logic [31:0] ins, p0, prev0, nxt;
        logic [3:0] op;
        exp_t ex;
        bit z, nz;
        int d;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: op = OP_JMP;
                1: op = OP_BEQZ;
                2: op = OP_RET;
                default: op = 4'($urandom_range(0, 9));
            endcase
            ins = {op, 28'($urandom)};
            z = 1'($urandom_range(0, 1));
            nz = 1'($urandom_range(0, 1));
            d = $urandom_range(0, 6);
            p0 = pc;
            prev0 = prev_pc;
            ex = ref_cmd(ins, z, p0);
            run_instr(ins, z, d, nz);
            nxt = ex.prev ? prev0 : (ex.jump ? ex.pcd : p0 + 32'd1);
            checks++;
            if (obs_tmo || obs_addr !== p0 || obs_instr !== ins) begin
                errors++;
                $display("FAIL rand_fetch[%0d]: got tmo=%b addr=%h instr=%h want 0 %h %h",
                         i, obs_tmo, obs_addr, obs_instr, p0, ins);
            end
            checks++;
            if ({obs_en, obs_jump, obs_prev, obs_valid} !== {1'b1, ex.jump, ex.prev, 1'b1}
                || obs_pcd !== ex.pcd) begin
                errors++;
                $display("FAIL rand_cmd[%0d] instr=%h z=%b: got %b pcd=%h want %b pcd=%h",
                         i, ins, z, {obs_en, obs_jump, obs_prev, obs_valid}, obs_pcd,
                         {1'b1, ex.jump, ex.prev, 1'b1}, ex.pcd);
            end
            checks++;
            if (obs_en_after !== 1'b0 || obs_addr_after !== nxt) begin
                errors++;
                $display("FAIL rand_next[%0d]: got en=%b addr=%h want 0 %h",
                         i, obs_en_after, obs_addr_after, nxt);
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        @(negedge cstate);
        rst = 1'b0;
        @(negedge cstate);
        checks++;
        if ({imem_req, imem_addr, pc_en, pc_d, instr_out, instr_valid, halted, fetch_err} !== 101'd0) begin
            errors++;
            $display("FAIL reset_mid_fetch: got req=%b addr=%h instr=%h want all 0",
                     imem_req, imem_addr, instr_out);
        end
        rst = 1'b1;
        @(negedge cstate);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== pc) begin
            errors++;
            $display("FAIL refetch_after_reset: got req=%b addr=%h want 1 %h",
                     imem_req, imem_addr, pc);
        end
    endtask

    task automatic test_timeout();
        repeat (TIMEOUT - 1) @(negedge cstate);
        checks++;
        if ({imem_req, fetch_err, halted} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_early: got req/err/halted=%b want 100",
                     {imem_req, fetch_err, halted});
        end
        @(negedge cstate);
        checks++;
        if ({imem_req, fetch_err, halted} !== 3'b011) begin
            errors++;
            $display("FAIL timeout_hit: got req/err/halted=%b want 011",
                     {imem_req, fetch_err, halted});
        end
        imem_ack = 1'b1;
        @(negedge cstate);
        imem_ack = 1'b0;
        @(negedge cstate);
        checks++;
        if ({imem_req, fetch_err, halted, pc_en} !== 4'b0110) begin
            errors++;
            $display("FAIL timeout_sticky: got req/err/halted/en=%b want 0110",
                     {imem_req, fetch_err, halted, pc_en});
        end
        rst = 1'b0;
        @(negedge cstate);
        checks++;
        if ({imem_req, fetch_err, halted} !== 3'b000) begin
            errors++;
            $display("FAIL timeout_clear: got req/err/halted=%b want 000",
                     {imem_req, fetch_err, halted});
        end
        rst = 1'b1;
        @(negedge cstate);
    endtask

    task automatic test_halt();
        run_instr(32'hF000_0000, 1'b0, 2, 1'b0);
        checks++;
        if ({obs_en, obs_jump, obs_prev, obs_valid} !== 4'b1001
            || {obs_req_after, obs_halted_after, obs_en_after} !== 3'b010) begin
            errors++;
            $display("FAIL hlt_cmd: got %b after req/halted/en=%b want 1001 010",
                     {obs_en, obs_jump, obs_prev, obs_valid},
                     {obs_req_after, obs_halted_after, obs_en_after});
        end
        imem_ack = 1'b1;
        @(negedge cstate);
        imem_ack = 1'b0;
        repeat (3) @(negedge cstate);
        checks++;
        if ({imem_req, pc_en, instr_valid, pc_jumping, pc_gotoprev, halted, fetch_err} !== 7'b0000010) begin
            errors++;
            $display("FAIL halt_hold: got %b want 0000010",
                     {imem_req, pc_en, instr_valid, pc_jumping, pc_gotoprev, halted, fetch_err});
        end
        rst = 1'b0;
        @(negedge cstate);
        rst = 1'b1;
        @(negedge cstate);
        checks++;
        if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== pc) begin
            errors++;
            $display("FAIL halt_exit: got halted=%b req=%b addr=%h want 0 1 %h",
                     halted, imem_req, imem_addr, pc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu();
        test_jmp();
        test_beqz();
        test_ret();
        test_ack_boundary();
        test_random();
        test_reset_mid_fetch();
        test_timeout();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
